// File: rtl/ysyx_23060061_axi_rr_arbiter_if.sv
// Bundle of every handshake/bus signal around the IFU/LSU AXI arbiter.
// Requester m0 (IFU) is read-only, requester m1 (LSU) reads and writes;
// both use 32-bit AXI-Lite-style channels. io_master_* is the shared
// single-beat 64-bit AXI4 master port.
// Modports:
//   master - arbiter view (drives requester responses and downstream requests)
//   slave  - environment view (requesters plus downstream memory slave)
interface ysyx_23060061_axi_rr_arbiter_if;
  logic [31:0] m0_araddr;
  logic        m0_arvalid;
  logic        m0_arready;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rvalid;
  logic        m0_rready;

  logic [31:0] m1_araddr;
  logic        m1_arvalid;
  logic        m1_arready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rvalid;
  logic        m1_rready;
  logic [31:0] m1_awaddr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_awvalid;
  logic        m1_wvalid;
  logic        m1_awready;
  logic        m1_wready;
  logic [1:0]  m1_bresp;
  logic        m1_bvalid;
  logic        m1_bready;

  logic        io_master_arvalid;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_arready;
  logic        io_master_awvalid;
  logic [31:0] io_master_awaddr;
  logic [3:0]  io_master_awid;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;
  logic        io_master_awready;
  logic        io_master_wvalid;
  logic [63:0] io_master_wdata;
  logic [7:0]  io_master_wstrb;
  logic        io_master_wlast;
  logic        io_master_wready;
  logic        io_master_rready;
  logic        io_master_rvalid;
  logic [63:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic        io_master_rlast;
  logic [3:0]  io_master_rid;
  logic        io_master_bready;
  logic        io_master_bvalid;
  logic [1:0]  io_master_bresp;
  logic [3:0]  io_master_bid;

  modport master (
    input  m0_araddr, m0_arvalid, m0_rready,
    output m0_arready, m0_rdata, m0_rresp, m0_rvalid,
    input  m1_araddr, m1_arvalid, m1_rready,
    output m1_arready, m1_rdata, m1_rresp, m1_rvalid,
    input  m1_awaddr, m1_wdata, m1_wstrb, m1_awvalid, m1_wvalid, m1_bready,
    output m1_awready, m1_wready, m1_bresp, m1_bvalid,
    output io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
    output io_master_arsize, io_master_arburst,
    input  io_master_arready,
    output io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
    output io_master_awsize, io_master_awburst,
    input  io_master_awready,
    output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
    input  io_master_wready,
    output io_master_rready,
    input  io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid,
    output io_master_bready,
    input  io_master_bvalid, io_master_bresp, io_master_bid
  );

  modport slave (
    output m0_araddr, m0_arvalid, m0_rready,
    input  m0_arready, m0_rdata, m0_rresp, m0_rvalid,
    output m1_araddr, m1_arvalid, m1_rready,
    input  m1_arready, m1_rdata, m1_rresp, m1_rvalid,
    output m1_awaddr, m1_wdata, m1_wstrb, m1_awvalid, m1_wvalid, m1_bready,
    input  m1_awready, m1_wready, m1_bresp, m1_bvalid,
    input  io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
    input  io_master_arsize, io_master_arburst,
    output io_master_arready,
    input  io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
    input  io_master_awsize, io_master_awburst,
    output io_master_awready,
    input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
    output io_master_wready,
    input  io_master_rready,
    output io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid,
    input  io_master_bready,
    output io_master_bvalid, io_master_bresp, io_master_bid
  );
endinterface

// File: rtl/ysyx_23060061_axi_rr_arbiter.sv
// Shares the single 64-bit AXI4 master port between IFU (m0, reads) and
// LSU (m1, reads/writes). One transaction in flight; writes outrank reads,
// simultaneous reads are granted round-robin. Each grant becomes a single
// 32-bit beat on the 64-bit bus, steered by address bit 2.
// Ports:
//   clock - system clock
//   reset - synchronous, active-high
//   bus   - requester and downstream channels (master modport)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; grant decided combinationally here
// RD_ADDR | io_master_arvalid up with latched address
// RD_DATA | io_master_rready up, waiting for downstream read data
// RD_RESP | granted requester's rvalid up with latched data
// WR_REQ  | aw/w valids up, each dropped after its own handshake
// WR_RESP | io_master_bready up, waiting for write response
// WR_ACK  | m1_bvalid up until m1_bready
module ysyx_23060061_axi_rr_arbiter (
  input logic clock,
  input logic reset,
  ysyx_23060061_axi_rr_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, RD_RESP, WR_REQ, WR_RESP, WR_ACK
  } state_t;

  state_t      state, state_nxt;
  logic        last;      // most recent read grant: 0 = m0, 1 = m1
  logic        sel;       // requester owning the current read
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [1:0]  bresp;
  logic        aw_done;
  logic        w_done;
  logic        grant_wr, grant_m0, grant_m1;
  logic        aw_hs, w_hs;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      sel     <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      rdata   <= '0;
      rresp   <= '0;
      bresp   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_m0 || grant_m1) begin
        addr <= grant_m1 ? bus.m1_araddr : bus.m0_araddr;
        sel  <= grant_m1;
        last <= grant_m1;
      end
      if (grant_wr) begin
        addr    <= bus.m1_awaddr;
        wdata   <= bus.m1_wdata;
        wstrb   <= bus.m1_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state == RD_DATA && bus.io_master_rvalid) begin
        rdata <= addr[2] ? bus.io_master_rdata[63:32] : bus.io_master_rdata[31:0];
        rresp <= bus.io_master_rresp;
      end
      if (state == WR_RESP && bus.io_master_bvalid) bresp <= bus.io_master_bresp;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_m0  = 1'b0;
    grant_m1  = 1'b0;
    aw_hs     = (state == WR_REQ) && !aw_done && bus.io_master_awready;
    w_hs      = (state == WR_REQ) && !w_done && bus.io_master_wready;

    bus.io_master_arvalid = 1'b0;
    bus.io_master_rready  = 1'b0;
    bus.io_master_awvalid = 1'b0;
    bus.io_master_wvalid  = 1'b0;
    bus.io_master_bready  = 1'b0;
    bus.m0_rvalid         = 1'b0;
    bus.m1_rvalid         = 1'b0;
    bus.m1_bvalid         = 1'b0;

    case (state)
      IDLE: begin
        // Gated by reset so no ready pulses while reset is held.
        if (!reset) begin
          if (bus.m1_awvalid && bus.m1_wvalid) grant_wr = 1'b1;
          else if (bus.m0_arvalid && bus.m1_arvalid) begin
            if (last) grant_m0 = 1'b1;
            else      grant_m1 = 1'b1;
          end
          else if (bus.m0_arvalid) grant_m0 = 1'b1;
          else if (bus.m1_arvalid) grant_m1 = 1'b1;
        end
        if (grant_wr) state_nxt = WR_REQ;
        else if (grant_m0 || grant_m1) state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        bus.io_master_arvalid = 1'b1;
        if (bus.io_master_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        bus.io_master_rready = 1'b1;
        if (bus.io_master_rvalid) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        bus.m0_rvalid = !sel;
        bus.m1_rvalid = sel;
        if (sel ? bus.m1_rready : bus.m0_rready) state_nxt = IDLE;
      end
      WR_REQ: begin
        bus.io_master_awvalid = !aw_done;
        bus.io_master_wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bus.io_master_bready = 1'b1;
        if (bus.io_master_bvalid) state_nxt = WR_ACK;
      end
      WR_ACK: begin
        bus.m1_bvalid = 1'b1;
        if (bus.m1_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.m0_arready = grant_m0;
  assign bus.m1_arready = grant_m1;
  assign bus.m1_awready = grant_wr;
  assign bus.m1_wready  = grant_wr;
  assign bus.m0_rdata   = rdata;
  assign bus.m1_rdata   = rdata;
  assign bus.m0_rresp   = rresp;
  assign bus.m1_rresp   = rresp;
  assign bus.m1_bresp   = bresp;

  assign bus.io_master_araddr  = addr;
  assign bus.io_master_arid    = 4'd0;
  assign bus.io_master_arlen   = 8'd0;
  assign bus.io_master_arsize  = 3'b010;
  assign bus.io_master_arburst = 2'b01;
  assign bus.io_master_awaddr  = addr;
  assign bus.io_master_awid    = 4'd0;
  assign bus.io_master_awlen   = 8'd0;
  assign bus.io_master_awsize  = 3'b010;
  assign bus.io_master_awburst = 2'b01;
  assign bus.io_master_wdata   = {wdata, wdata};
  assign bus.io_master_wstrb   = addr[2] ? {wstrb, 4'b0000} : {4'b0000, wstrb};
  assign bus.io_master_wlast   = bus.io_master_wvalid;

endmodule

// File: tb/tb_ysyx_23060061_axi_rr_arbiter.sv
module tb_ysyx_23060061_axi_rr_arbiter;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  ysyx_23060061_axi_rr_arbiter_if bus ();

  ysyx_23060061_axi_rr_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.m0_araddr = '0; bus.m0_arvalid = 1'b0; bus.m0_rready = 1'b1;
    bus.m1_araddr = '0; bus.m1_arvalid = 1'b0; bus.m1_rready = 1'b1;
    bus.m1_awaddr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
    bus.m1_awvalid = 1'b0; bus.m1_wvalid = 1'b0; bus.m1_bready = 1'b1;
    bus.io_master_arready = 1'b1; bus.io_master_awready = 1'b1; bus.io_master_wready = 1'b1;
    bus.io_master_rvalid = 1'b1; bus.io_master_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    bus.io_master_rresp = 2'd0; bus.io_master_rlast = 1'b1; bus.io_master_rid = 4'd0;
    bus.io_master_bvalid = 1'b1; bus.io_master_bresp = 2'd0; bus.io_master_bid = 4'd0;

    // reset for two edges, then all outputs idle
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_m0_arready", bus.m0_arready, 0);
    chk("rst_m1_arready", bus.m1_arready, 0);
    chk("rst_m1_awready", bus.m1_awready, 0);
    chk("rst_m1_wready", bus.m1_wready, 0);
    chk("rst_m0_rvalid", bus.m0_rvalid, 0);
    chk("rst_m1_rvalid", bus.m1_rvalid, 0);
    chk("rst_m1_bvalid", bus.m1_bvalid, 0);
    chk("rst_arvalid", bus.io_master_arvalid, 0);
    chk("rst_awvalid", bus.io_master_awvalid, 0);
    chk("rst_wvalid", bus.io_master_wvalid, 0);
    chk("rst_rready", bus.io_master_rready, 0);
    chk("rst_bready", bus.io_master_bready, 0);
    chk("rst_m0_rdata", bus.m0_rdata, 0);
    chk("rst_m1_bresp", bus.m1_bresp, 0);

    // simultaneous reads, both held: m0 first, then alternation
    bus.m0_araddr = 32'h8000_0000; bus.m1_araddr = 32'h8000_0004;
    bus.m0_arvalid = 1'b1; bus.m1_arvalid = 1'b1;
    #1;
    chk("tie_m0_arready", bus.m0_arready, 1);
    chk("tie_m1_arready", bus.m1_arready, 0);
    @(negedge clock); // C1
    chk("c1_arvalid", bus.io_master_arvalid, 1);
    chk("c1_araddr", bus.io_master_araddr, 64'h8000_0000);
    chk("c1_arsize", bus.io_master_arsize, 3'b010);
    chk("c1_arburst", bus.io_master_arburst, 2'b01);
    chk("c1_m0_arready", bus.m0_arready, 0);
    @(negedge clock); // C2
    chk("c2_rready", bus.io_master_rready, 1);
    chk("c2_arvalid", bus.io_master_arvalid, 0);
    @(negedge clock); // C3
    chk("c3_m0_rvalid", bus.m0_rvalid, 1);
    chk("c3_m0_rdata", bus.m0_rdata, 32'hCCCC_DDDD);
    chk("c3_m1_rvalid", bus.m1_rvalid, 0);
    @(negedge clock); // C4
    chk("c4_m1_arready", bus.m1_arready, 1);
    chk("c4_m0_arready", bus.m0_arready, 0);
    @(negedge clock); // C5
    chk("c5_araddr", bus.io_master_araddr, 64'h8000_0004);
    @(negedge clock); // C6
    @(negedge clock); // C7
    chk("c7_m1_rvalid", bus.m1_rvalid, 1);
    chk("c7_m1_rdata", bus.m1_rdata, 32'hAAAA_BBBB);
    chk("c7_m0_rvalid", bus.m0_rvalid, 0);
    @(negedge clock); // C8
    chk("c8_m0_arready", bus.m0_arready, 1);
    repeat (4) @(negedge clock); // C12
    chk("c12_m1_arready", bus.m1_arready, 1);

    // m1 read of the upper half with a new data pattern
    @(negedge clock); // C13
    bus.m0_arvalid = 1'b0; bus.m1_arvalid = 1'b0;
    bus.io_master_rdata = 64'h1111_2222_3333_4444;
    @(negedge clock); // C14
    @(negedge clock); // C15
    chk("rd_m1_rvalid", bus.m1_rvalid, 1);
    chk("rd_m1_rdata", bus.m1_rdata, 32'h1111_2222);
    chk("rd_m1_rresp", bus.m1_rresp, 2'd0);
    bus.m1_rready = 1'b0;
    @(negedge clock); // C16
    chk("rd_hold_rvalid", bus.m1_rvalid, 1);
    chk("rd_hold_rdata", bus.m1_rdata, 32'h1111_2222);
    bus.m1_rready = 1'b1;
    @(negedge clock); // C17
    chk("rd_done_rvalid", bus.m1_rvalid, 0);

    // write with delayed awready
    bus.m1_awaddr = 32'h8000_0004; bus.m1_wdata = 32'hDEAD_BEEF; bus.m1_wstrb = 4'b0011;
    bus.m1_awvalid = 1'b1; bus.m1_wvalid = 1'b1;
    bus.io_master_awready = 1'b0; bus.io_master_wready = 1'b1;
    bus.io_master_bvalid = 1'b0; bus.io_master_bresp = 2'd2;
    #1;
    chk("w0_awready", bus.m1_awready, 1);
    chk("w0_wready", bus.m1_wready, 1);
    @(negedge clock); // W1
    bus.m1_awvalid = 1'b0; bus.m1_wvalid = 1'b0;
    chk("w1_awvalid", bus.io_master_awvalid, 1);
    chk("w1_wvalid", bus.io_master_wvalid, 1);
    chk("w1_wlast", bus.io_master_wlast, 1);
    chk("w1_awaddr", bus.io_master_awaddr, 64'h8000_0004);
    chk("w1_wdata", bus.io_master_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("w1_wstrb", bus.io_master_wstrb, 8'h30);
    chk("w1_m1_awready", bus.m1_awready, 0);
    @(negedge clock); // W2
    chk("w2_wvalid", bus.io_master_wvalid, 0);
    chk("w2_awvalid", bus.io_master_awvalid, 1);
    chk("w2_bready", bus.io_master_bready, 0);
    @(negedge clock); // W3
    chk("w3_awvalid", bus.io_master_awvalid, 1);
    chk("w3_awaddr", bus.io_master_awaddr, 64'h8000_0004);
    bus.io_master_awready = 1'b1;
    @(negedge clock); // W4
    chk("w4_bready", bus.io_master_bready, 1);
    chk("w4_awvalid", bus.io_master_awvalid, 0);
    bus.io_master_bvalid = 1'b1;
    @(negedge clock); // W5
    chk("w5_m1_bvalid", bus.m1_bvalid, 1);
    chk("w5_m1_bresp", bus.m1_bresp, 2'd2);
    chk("w5_bready", bus.io_master_bready, 0);
    bus.m1_bready = 1'b0;
    @(negedge clock); // W6
    chk("w6_m1_bvalid", bus.m1_bvalid, 1);
    bus.m1_bready = 1'b1;
    @(negedge clock); // W7
    chk("w7_m1_bvalid", bus.m1_bvalid, 0);

    // write beats simultaneous reads; next read goes to the one not last (m0)
    bus.io_master_bresp = 2'd0;
    bus.m1_awaddr = 32'h8000_0000; bus.m1_wstrb = 4'b1111;
    bus.m1_awvalid = 1'b1; bus.m1_wvalid = 1'b1;
    bus.m1_arvalid = 1'b1; bus.m0_arvalid = 1'b1;
    #1;
    chk("pri_m1_awready", bus.m1_awready, 1);
    chk("pri_m0_arready", bus.m0_arready, 0);
    chk("pri_m1_arready", bus.m1_arready, 0);
    @(negedge clock); // P1
    bus.m1_awvalid = 1'b0; bus.m1_wvalid = 1'b0;
    chk("p1_awvalid", bus.io_master_awvalid, 1);
    chk("p1_wstrb", bus.io_master_wstrb, 8'h0F);
    @(negedge clock); // P2
    @(negedge clock); // P3
    chk("p3_m1_bvalid", bus.m1_bvalid, 1);
    @(negedge clock); // P4
    chk("p4_m0_arready", bus.m0_arready, 1);
    chk("p4_m1_arready", bus.m1_arready, 0);
    @(negedge clock); // P5
    bus.m0_arvalid = 1'b0; bus.m1_arvalid = 1'b0;
    @(negedge clock); // P6
    chk("p6_rready", bus.io_master_rready, 1);

    // reset while waiting for read data
    reset = 1'b1;
    bus.io_master_rvalid = 1'b0;
    @(negedge clock); // P7
    chk("rr_rready", bus.io_master_rready, 0);
    chk("rr_arvalid", bus.io_master_arvalid, 0);
    chk("rr_m0_rdata", bus.m0_rdata, 0);
    reset = 1'b0;
    bus.io_master_rvalid = 1'b1;
    @(negedge clock); // P8
    chk("late_m0_rvalid", bus.m0_rvalid, 0);
    chk("late_m1_rvalid", bus.m1_rvalid, 0);
    chk("late_rready", bus.io_master_rready, 0);
    @(negedge clock); // P9
    chk("late2_m0_rvalid", bus.m0_rvalid, 0);

    // last reset to 1: m0 wins the tie again
    bus.m0_arvalid = 1'b1; bus.m1_arvalid = 1'b1;
    #1;
    chk("rst_tie_m0", bus.m0_arready, 1);
    chk("rst_tie_m1", bus.m1_arready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
